// File: rtl/relu_bwd_if.sv
// relu_bwd_if: stream bundle for the ReLU backward unit.
//   fwd_*      : forward pre-activation stream (mask recording)
//   grad_in_*  : upstream gradient stream
//   grad_out_* : masked gradient stream
// master drives stimulus/consumes results; slave is the relu_bwd side.
interface relu_bwd_if #(
  parameter int WIDTH = 16
);
  logic             fwd_val;
  logic             fwd_rdy;
  logic [WIDTH-1:0] fwd_in;
  logic             grad_in_val;
  logic             grad_in_rdy;
  logic [WIDTH-1:0] grad_in;
  logic             grad_out_val;
  logic             grad_out_rdy;
  logic [WIDTH-1:0] grad_out;

  modport master (
    output fwd_val, fwd_in, grad_in_val, grad_in, grad_out_rdy,
    input  fwd_rdy, grad_in_rdy, grad_out_val, grad_out
  );

  modport slave (
    input  fwd_val, fwd_in, grad_in_val, grad_in, grad_out_rdy,
    output fwd_rdy, grad_in_rdy, grad_out_val, grad_out
  );
endinterface

// File: rtl/relu_bwd.sv
// relu_bwd: backward pass of ReLU for the Q8.8 datapath.
// Records one derivative bit per forward pre-activation (1 when strictly
// positive) into a mask FIFO, then gates incoming gradients in the same order.
// Ports:
//   clk   : clock, rising edge
//   rst   : asynchronous reset, active low
//   flush : synchronous clear of mask FIFO and output register
//   bus   : fwd / grad_in / grad_out valid-ready streams (slave side)
//   count : number of mask bits currently stored
module relu_bwd #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  relu_bwd_if.slave                bus,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DEPTH-1:0] mask_mem;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             out_val;
  logic [WIDTH-1:0] out_data;
  logic             fwd_xfer;
  logic             grad_xfer;
  logic             fwd_mask;
  logic             pop_mask;

  // Derivative at exactly zero is taken as 0.
  assign fwd_mask = !bus.fwd_in[WIDTH-1] && (bus.fwd_in != '0);
  assign pop_mask = mask_mem[rd_ptr];

  // rst folded in so fwd_rdy drops immediately on reset assertion.
  assign bus.fwd_rdy     = rst && !flush && (count != CW'(DEPTH));
  // No push-to-pop bypass: readiness comes from registered count only.
  assign bus.grad_in_rdy = !flush && (count != '0) && (!out_val || bus.grad_out_rdy);

  assign fwd_xfer  = bus.fwd_val && bus.fwd_rdy;
  assign grad_xfer = bus.grad_in_val && bus.grad_in_rdy;

  assign bus.grad_out_val = out_val;
  assign bus.grad_out     = out_data;

  // Mask storage needs no reset: entries are only read when count says valid.
  always_ff @(posedge clk) begin
    if (fwd_xfer) begin
      mask_mem[wr_ptr] <= fwd_mask;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      out_val  <= 1'b0;
      out_data <= '0;
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      out_val  <= 1'b0;
      out_data <= '0;
    end else begin
      if (fwd_xfer) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (grad_xfer) begin
        rd_ptr <= rd_ptr + PW'(1);
      end

      unique case ({fwd_xfer, grad_xfer})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase

      // A new gradient reloads the register even while the old beat leaves.
      if (grad_xfer) begin
        out_val  <= 1'b1;
        out_data <= pop_mask ? bus.grad_in : '0;
      end else if (bus.grad_out_rdy) begin
        out_val  <= 1'b0;
      end
    end
  end
endmodule

// File: doc/relu_bwd.md
# relu_bwd

Backward-pass counterpart of the ReLU activation unit for the NPU's Q8.8 datapath. During the forward pass it records one derivative bit per activation, 1 when the pre-activation is strictly positive and 0 otherwise, into an internal mask FIFO. During the backward pass it reads those bits in the same order to gate incoming gradients. It sits beside the forward ReLU on the activation stream and in front of the weight-gradient accumulator on the gradient stream. All streams use valid/ready handshakes.

## Interface
- WIDTH, 16: data width in bits (signed Q8.8 at default).
- DEPTH, 64: mask FIFO capacity in entries; must be a power of two and at least 2.

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous reset, active-low; one clock
- flush  in  1  synchronous clear of mask FIFO and output register; no effect while rst is asserted
- fwd_val  in  1  forward pre-activation valid
- fwd_rdy  out  1  forward pre-activation ready
- fwd_in  in  WIDTH  signed pre-activation (same value fed to the forward ReLU)
- grad_in_val  in  1  upstream gradient valid
- grad_in_rdy  out  1  upstream gradient ready
- grad_in  in  WIDTH  signed upstream gradient
- grad_out_val  out  1  masked gradient valid
- grad_out_rdy  in  1  downstream ready
- grad_out  out  WIDTH  masked gradient
- count  out  $clog2(DEPTH)+1  number of mask bits currently stored

## Operation
- Mask bit: mask = (fwd_in[WIDTH-1] == 0) && (fwd_in != 0). Zero input gives mask 0, so the derivative at 0 is defined as 0.
- Forward transfer (fwd_val && fwd_rdy): the mask bit is written at the write pointer, and the write pointer advances modulo DEPTH.
- fwd_rdy = (count != DEPTH) && !flush. It is derived from registered count only; there is no bypass from a same-cycle pop.
- Gradient transfer (grad_in_val && grad_in_rdy):
  - The mask is popped at the read pointer.
  - The output register loads grad_in if mask==1, otherwise all zeros.
  - grad_out_val is set to 1.
- grad_in_rdy = (count != 0) && (!grad_out_val || grad_out_rdy) && !flush. There is no push-to-pop bypass: a mask written in cycle N is poppable no earlier than cycle N+1.
- Output transfer (grad_out_val && grad_out_rdy) with no simultaneous gradient transfer clears grad_out_val. With a simultaneous gradient transfer, the register reloads and grad_out_val stays 1.
- grad_out is held stable while grad_out_val && !grad_out_rdy.
- count update: +1 on forward transfer only, -1 on gradient transfer only, unchanged on both or neither. Simultaneous push and pop are legal at any fill level where both readies are high.
- Pointers are $clog2(DEPTH) bits and wrap from DEPTH-1 to 0. Full and empty are distinguished by count, not by pointer equality.
- Order is strictly FIFO: the k-th gradient accepted is gated by the k-th mask recorded since the last reset or flush.
- Flush (registered at the clock edge):
  - Pointers and count go to 0 and grad_out_val goes to 0.
  - Any handshakes in that cycle are discarded; both readies are low during flush.
- Gradient data is not modified beyond gating: no saturation or rounding, and grad_out is bit-exact to grad_in or 0.

## Timing
- Reset values, applied immediately on rst low independent of clk: fwd_rdy=0 while rst low, grad_in_rdy=0, grad_out_val=0, grad_out=0, count=0, pointers=0.
- First cycle after reset release: fwd_rdy=1 and grad_in_rdy=0 (empty).
- Latency from gradient acceptance to grad_out_val is 1 cycle.
- Throughput is 1 gradient per cycle with grad_out_rdy held high, and 1 forward entry per cycle while not full.
- Reset asserted mid-stream drops all stored masks and any pending output; no output beat completes after reset assertion.
- Minimum forward-to-backward gap: a mask pushed at edge N enables grad_in_rdy in the cycle after edge N.

## Test plan
- Reset:
  - Stimulus: assert rst low mid-stream with count=5 and grad_out_val=1.
  - Required: all outputs reach reset values without a clock edge; after release count=0, fwd_rdy=1, grad_in_rdy=0.
- Basic:
  - Stimulus: push fwd_in 0x0100, 0xff00, 0x0000, 0x0001; then grads 0x1234, 0x1234, 0x1234, 0x8000 with grad_out_rdy=1.
  - Required: grad_out is 0x1234, 0x0000, 0x0000, 0x8000, each one cycle after acceptance; count ends at 0.
- Full/wrap:
  - Stimulus: push DEPTH+1 entries with alternating sign.
  - Required: fwd_rdy=0 after DEPTH pushes and count=DEPTH.
  - Stimulus: then drain 3 and push 3 more.
  - Required: pointers wrap, and gated outputs keep FIFO order across the wrap.
- Simultaneous:
  - Stimulus: at count=DEPTH/2, fwd and grad transfers every cycle for 20 cycles.
  - Required: count stays at DEPTH/2, and outputs match the masks recorded 32 pushes earlier.
- Backpressure:
  - Stimulus: hold grad_out_rdy=0 for 5 cycles with gradients pending.
  - Required: grad_out is stable, grad_in_rdy=0, and count is unchanged.
  - Stimulus: release grad_out_rdy.
  - Required: one beat per cycle resumes with no loss or duplication.
- Flush and random:
  - Stimulus: assert flush at count=7 with grad_out_val=1.
  - Required: next cycle count=0 and grad_out_val=0.
  - Stimulus: 10000 random Q8.8 pairs.
  - Required: each output matches the reference model (fwd_in>0 ? grad_in : 0).
